// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, imem req/ack handshake,
// registered instruction hand-off and branch/sequential PC update.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [15:0] branch_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   br_off;
  logic [31:0]   pc_inc;

  assign pc_inc = pc_q + 32'd4;
  assign br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        // an ack in the final allowed cycle still counts as success
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = S_VALID;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_d    = PCSrc ? (pc_inc + br_off) : pc_inc;
          state_d = run_en ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign fetch_err   = err_q;

endmodule
